// File: rtl/relu_stream_array.sv
// Back-pressured ReLU activation array with a per-lane activation mask FIFO:
// forward beats can record which lanes passed, backward beats replay that mask onto gradients.
module relu_stream_array #(
    parameter int dataWidth   = 32,
    parameter int pactivation = 128,
    parameter int maskDepth   = 64
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [1:0]                        mode,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [dataWidth*pactivation-1:0]  in_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [dataWidth*pactivation-1:0]  out_data,
    output logic [1:0]                        out_mode,
    input  logic                              clear_mask,
    output logic [$clog2(maskDepth):0]        mask_count,
    output logic                              mask_full,
    output logic                              mask_empty,
    output logic                              err_underflow
);

    localparam int AW = $clog2(maskDepth);
    localparam int CW = AW + 1;

    localparam logic [1:0] MODE_BYPASS = 2'b00;
    localparam logic [1:0] MODE_RELU   = 2'b01;
    localparam logic [1:0] MODE_SAVE   = 2'b10;
    localparam logic [1:0] MODE_BACK   = 2'b11;

    logic [pactivation-1:0]           mask_mem [maskDepth];
    logic [AW-1:0]                    wr_ptr;
    logic [AW-1:0]                    rd_ptr;
    logic [CW-1:0]                    count_next;
    logic [pactivation-1:0]           pos;
    logic [pactivation-1:0]           mask_head;
    logic [dataWidth*pactivation-1:0] result;
    logic                             accept;
    logic                             push;
    logic                             pop;
    logic                             underflow;

    // Strictly positive: sign clear and magnitude nonzero, so +0 and -0 both block.
    function automatic logic lane_pos(input logic [dataWidth-1:0] x);
        return ~x[dataWidth-1] & (|x[dataWidth-2:0]);
    endfunction

    assign in_ready  = rst & (~out_valid | out_ready) & ~clear_mask
                     & ~((mode == MODE_SAVE) & mask_full);
    assign accept    = in_valid & in_ready;
    assign push      = accept & (mode == MODE_SAVE);
    assign pop       = accept & (mode == MODE_BACK) & ~mask_empty;
    assign underflow = accept & (mode == MODE_BACK) & mask_empty;
    assign mask_head = mask_mem[rd_ptr];

    // Per-lane result selection for the beat being offered.
    always_comb begin
        pos    = '0;
        result = '0;
        for (int i = 0; i < pactivation; i++) begin
            pos[i] = lane_pos(in_data[i*dataWidth +: dataWidth]);
            case (mode)
                MODE_BYPASS: result[i*dataWidth +: dataWidth] = in_data[i*dataWidth +: dataWidth];
                MODE_RELU,
                MODE_SAVE:   result[i*dataWidth +: dataWidth] = pos[i] ? in_data[i*dataWidth +: dataWidth]
                                                                       : {dataWidth{1'b0}};
                MODE_BACK:   result[i*dataWidth +: dataWidth] = (mask_head[i] & ~mask_empty)
                                                                       ? in_data[i*dataWidth +: dataWidth]
                                                                       : {dataWidth{1'b0}};
                default:     result[i*dataWidth +: dataWidth] = {dataWidth{1'b0}};
            endcase
        end
    end

    // Occupancy after this edge; push and pop are exclusive because the mode is per beat.
    always_comb begin
        count_next = mask_count;
        if (clear_mask) begin
            count_next = {CW{1'b0}};
        end else if (push) begin
            count_next = mask_count + 1'b1;
        end else if (pop) begin
            count_next = mask_count - 1'b1;
        end else begin
            count_next = mask_count;
        end
    end

    // Mask storage needs no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mask_mem[wr_ptr] <= pos;
        end
    end

    // Pointers, registered status flags, sticky error and the output stage.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr        <= {AW{1'b0}};
            rd_ptr        <= {AW{1'b0}};
            mask_count    <= {CW{1'b0}};
            mask_full     <= 1'b0;
            mask_empty    <= 1'b1;
            err_underflow <= 1'b0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_mode      <= 2'b00;
        end else begin
            if (clear_mask) begin
                wr_ptr <= {AW{1'b0}};
                rd_ptr <= {AW{1'b0}};
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
            end
            mask_count <= count_next;
            mask_full  <= (count_next == CW'(maskDepth));
            mask_empty <= (count_next == {CW{1'b0}});
            if (underflow) begin
                err_underflow <= 1'b1;
            end
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= result;
                out_mode  <= mode;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
